// File: rtl/seq_mult_ctrl.sv
// rtl/seq_mult_ctrl.sv - sequential shift-and-add multiplier controller with window pointer
module seq_mult_ctrl #(
    parameter int WIDTH   = 8,
    parameter bit SIGNED  = 1'b1,
    parameter int WIN_MAX = 2,
    localparam int WW     = (WIN_MAX > 0) ? $clog2(WIN_MAX + 1) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [WIDTH-1:0]   num1,
    input  logic [WIDTH-1:0]   num2,
    input  logic               start_btn,
    input  logic               shift_left_btn,
    input  logic               shift_right_btn,
    output logic [2*WIDTH-1:0] product,
    output logic               neg,
    output logic               busy,
    output logic               done,
    output logic               load,
    output logic               en,
    output logic [WW-1:0]      win_pos
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [WW-1:0] WIN_MAX_W = WW'(WIN_MAX);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_RUN, S_SIGN, S_DONE} state_t;

    state_t          state_q;
    logic            start_btn_q, left_btn_q, right_btn_q;
    logic [PW-1:0]   mcand_q, acc_q, product_q;
    logic [WIDTH-1:0] mult_q;
    logic [CW-1:0]   cnt_q;
    logic            sgn_q, neg_q, busy_q, done_q, load_q, en_q;
    logic [WW-1:0]   win_q;

    logic            start_edge, left_edge, right_edge;
    logic [WIDTH-1:0] abs1_d, abs2_d;
    logic            sgn_d;
    logic [PW-1:0]   addend_d;

    assign start_edge = start_btn & ~start_btn_q;
    assign left_edge  = shift_left_btn & ~left_btn_q;
    assign right_edge = shift_right_btn & ~right_btn_q;

    // The most negative operand negates to itself, which reads correctly as an unsigned magnitude.
    assign abs1_d   = (SIGNED && num1[WIDTH-1]) ? -num1 : num1;
    assign abs2_d   = (SIGNED && num2[WIDTH-1]) ? -num2 : num2;
    assign sgn_d    = SIGNED ? (num1[WIDTH-1] ^ num2[WIDTH-1]) : 1'b0;
    assign addend_d = mult_q[0] ? mcand_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            start_btn_q <= 1'b0;
            left_btn_q  <= 1'b0;
            right_btn_q <= 1'b0;
            mcand_q     <= '0;
            acc_q       <= '0;
            product_q   <= '0;
            mult_q      <= '0;
            cnt_q       <= '0;
            sgn_q       <= 1'b0;
            neg_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            load_q      <= 1'b0;
            en_q        <= 1'b0;
            win_q       <= '0;
        end else begin
            start_btn_q <= start_btn;
            left_btn_q  <= shift_left_btn;
            right_btn_q <= shift_right_btn;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_edge) begin
                        state_q <= S_LOAD;
                        win_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        load_q  <= 1'b1;
                    end else if (left_edge && !right_edge && win_q != WIN_MAX_W) begin
                        win_q <= win_q + 1'b1;
                    end else if (right_edge && !left_edge && win_q != '0) begin
                        win_q <= win_q - 1'b1;
                    end
                end
                S_LOAD: begin
                    mcand_q <= {{WIDTH{1'b0}}, abs1_d};
                    mult_q  <= abs2_d;
                    acc_q   <= '0;
                    cnt_q   <= '0;
                    sgn_q   <= sgn_d;
                    load_q  <= 1'b0;
                    en_q    <= 1'b1;
                    state_q <= S_RUN;
                end
                S_RUN: begin
                    acc_q   <= acc_q + addend_d;
                    mcand_q <= mcand_q << 1;
                    mult_q  <= mult_q >> 1;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        en_q    <= 1'b0;
                        state_q <= S_SIGN;
                    end
                end
                S_SIGN: begin
                    product_q <= sgn_q ? -acc_q : acc_q;
                    neg_q     <= sgn_q & (|acc_q);
                    busy_q    <= 1'b0;
                    done_q    <= 1'b1;
                    state_q   <= S_DONE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    load_q  <= 1'b0;
                    en_q    <= 1'b0;
                end
            endcase
        end
    end

    assign product = product_q;
    assign neg     = neg_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign load    = load_q;
    assign en      = en_q;
    assign win_pos = win_q;
endmodule

// File: doc/seq_mult_ctrl.md
Name: seq_mult_ctrl

Overview:
- Parametrised sequential shift-and-add multiplier controller for the board-level datapath; generalises the fixed 8-bit start/reset/shift-button flow to any operand WIDTH.
- Adds an optional signed mode, a busy/done handshake, rising-edge detection on all control inputs, and a saturating display-window pointer for the digit scroller.
- Sits between the button conditioners (debounced, synchronised levels) and the display formatter; the formatter consumes product, neg and win_pos.

Parameters:
- WIDTH, 8, operand width in bits (>=2); product is 2*WIDTH bits.
- SIGNED, 1, 1 = operands are two's complement; 0 = operands are unsigned.
- WIN_MAX, 2, maximum value of the display-window pointer.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  synchronous, active-high reset.
- num1  input  WIDTH  multiplicand operand.
- num2  input  WIDTH  multiplier operand.
- start_btn  input  1  start level; acted on at its rising edge.
- shift_left_btn  input  1  window-left level; acted on at its rising edge.
- shift_right_btn  input  1  window-right level; acted on at its rising edge.
- product  output  2*WIDTH  final result, two's complement when SIGNED=1.
- neg  output  1  result is negative (sign flag for the formatter).
- busy  output  1  high during the LOAD, RUN and SIGN states.
- done  output  1  high in the DONE state.
- load  output  1  high in the LOAD state only.
- en  output  1  high in the RUN state only.
- win_pos  output  clog2(WIN_MAX+1)  display-window pointer.

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; product, neg, busy, done, load, en and win_pos are all 0; internal registers and edge-detect flops are cleared. The same applies mid-operation: any in-flight result is discarded.
- Edge detect: each button is registered (btn_q). An edge is btn & ~btn_q. A held level produces exactly one edge. The btn_q flops reset to 0, so a button high on the first edge after reset counts as an edge.
- State IDLE/DONE, start edge -> LOAD. product and neg hold their old values until SIGN.
- LOAD (1 cycle):
  - mcand_reg = |num1| zero-extended to 2*WIDTH; mult_reg = |num2|; acc = 0; cnt = 0.
  - sgn = num1[MSB]^num2[MSB] if SIGNED, else 0.
  - |x| of the most negative value is 2^(WIDTH-1), which is representable unsigned in WIDTH bits.
  - Operands are sampled only here; later changes to num1/num2 are ignored.
- RUN (exactly WIDTH cycles, no early exit):
  - If mult_reg[0]=1, acc += mcand_reg, computed modulo 2^(2*WIDTH); no overflow is possible.
  - mcand_reg <<= 1; mult_reg >>= 1; cnt++.
  - Go to SIGN when cnt==WIDTH-1.
- SIGN (1 cycle): product = sgn ? -acc : acc; neg = sgn & (acc!=0), so a zero result is never negative; go to DONE.
- DONE: done=1, held until the next start edge or rst.
- Latency: start edge sampled at edge N -> LOAD after N, RUN after N+1, SIGN after N+1+WIDTH; product valid and done=1 after edge N+2+WIDTH.
- Start edges while busy=1 are ignored and are not queued.
- Window pointer:
  - Active only when busy=0.
  - shift_left edge: win_pos+1, saturating at WIN_MAX.
  - shift_right edge: win_pos-1, saturating at 0.
  - Both edges in the same cycle: no change.
  - Edges while busy are dropped.
  - win_pos is set to 0 on entry to LOAD.
- A start edge and a shift edge in the same IDLE/DONE cycle: start wins and win_pos is set to 0.

Test Plan:
- WIDTH=8, SIGNED=0: num1=13, num2=11, one start pulse -> busy for 10 cycles, done after edge N+10, product=16'h008F (143), neg=0.
- SIGNED=0: 255*255 -> product=16'hFE01; 0*255 -> product=0; each run takes exactly 10 cycles.
- SIGNED=1: -5*7 -> product=16'hFFDD, neg=1; -128*-128 -> 16'h4000, neg=0; -3*0 -> 0, neg=0.
- start_btn held high for 30 cycles -> exactly one operation; num1 changed during RUN -> result unchanged; start pulse during RUN -> ignored.
- rst asserted at RUN cycle 4 -> next cycle all outputs 0 and state IDLE; a fresh start then produces the correct product.
- WIN_MAX=2, IDLE: 4 shift_left edges -> win_pos=2; 3 shift_right edges -> 0; both edges in one cycle -> unchanged; shift edge while busy -> ignored; new start -> win_pos=0.
